fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/mips_pkg.sv | 19 +
 rtl/fetch_buffer_if.sv | 28 ++
 rtl/fetch_buffer_checker.sv | 14 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_buffer.sv | 112 +++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: datapath width, NOP encoding, PC step,
// and the {PC, instruction} entry stored by the fetch queue.
package mips_pkg;

  localparam int          DATA_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'h0000_0004;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] insn;
  } fetch_entry_t;

  // Sequential fetch step; wraps modulo 2^32 by construction.
  function automatic logic [DATA_W-1:0] next_pc(input logic [DATA_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer (master)
// and the instruction memory (slave).
interface fetch_buffer_if;
  import mips_pkg::*;

  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_valid;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_buffer_checker.sv
// Simulation checks on the fetch buffer's memory handshake.
module fetch_buffer_checker (
  input logic clk,
  input logic reset,
  input logic imem_valid,
  input logic none_outstanding
);

  // A response with nothing in flight means memory and the credit count disagree.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    !(imem_valid && none_outstanding))
    else $error("fetch_buffer: imem_valid with no outstanding request");

endmodule

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {PC, instruction} pairs with a zero-latency
// head read, an occupancy count and a single-cycle flush.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           push_data,
  output fetch_entry_t           head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W:0]   count_r;

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush wins over push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues credit-limited sequential fetches, queues
// returned words with their PCs, and squashes in-flight responses on redirect.
module fetch_buffer
  import mips_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_OUT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               jump,
  input  logic [DATA_W-1:0]  extended,
  fetch_buffer_if.master     imem,
  output logic [DATA_W-1:0]  Instruction_Code,
  output logic [DATA_W-1:0]  PC,
  output logic               insn_valid
);

  localparam int               CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0]  count_s;
  logic [CNT_W-1:0]  outstanding_r;
  logic [CNT_W-1:0]  drop_cnt_r;
  logic [CNT_W-1:0]  out_next_s;
  logic [CNT_W:0]    credit_s;
  logic [DATA_W-1:0] fetch_pc_r;
  logic [DATA_W-1:0] resp_pc_r;
  logic [DATA_W-1:0] last_pc_r;
  logic              req_s;
  logic              accept_s;
  logic              resp_s;
  logic              drop_s;
  logic              push_s;
  logic              pop_s;
  fetch_entry_t      head_s;
  fetch_entry_t      push_data_s;

  // Credits count queued plus in-flight words so a response always has a slot.
  always_comb begin
    credit_s    = {1'b0, count_s} + {1'b0, outstanding_r};
    req_s       = !reset && !jump && (credit_s < DEPTH_C) && (outstanding_r < MAX_OUT_C);
    accept_s    = req_s && imem.imem_ready;
    resp_s      = imem.imem_valid && (outstanding_r != '0);
    drop_s      = resp_s && (jump || (drop_cnt_r != '0));
    push_s      = resp_s && !drop_s;
    pop_s       = insn_valid && !stall && !jump;
    out_next_s  = outstanding_r + CNT_W'(accept_s) - CNT_W'(resp_s);
    push_data_s = '{pc: resp_pc_r, insn: imem.imem_rdata};
  end

  // Fetch/response PCs, credit and squash bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_r    <= RESET_PC;
      resp_pc_r     <= RESET_PC;
      last_pc_r     <= RESET_PC;
      outstanding_r <= '0;
      drop_cnt_r    <= '0;
    end else begin
      outstanding_r <= out_next_s;
      if (pop_s) begin
        last_pc_r <= head_s.pc;
      end
      if (jump) begin
        fetch_pc_r <= extended;
        resp_pc_r  <= extended;
        drop_cnt_r <= out_next_s;
      end else begin
        if (accept_s) begin
          fetch_pc_r <= next_pc(fetch_pc_r);
        end
        if (push_s) begin
          resp_pc_r <= next_pc(resp_pc_r);
        end
        if (drop_s) begin
          drop_cnt_r <= drop_cnt_r - CNT_W'(1);
        end
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (jump),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .head_data (head_s),
    .count     (count_s)
  );

  fetch_buffer_checker u_checker (
    .clk              (clk),
    .reset            (reset),
    .imem_valid       (imem.imem_valid),
    .none_outstanding (outstanding_r == '0)
  );

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = fetch_pc_r;

  // An empty queue shows a NOP while PC keeps the last instruction handed out.
  assign insn_valid       = (count_s != '0);
  assign Instruction_Code = insn_valid ? head_s.insn : NOP;
  assign PC               = insn_valid ? head_s.pc : last_pc_r;

endmodule
